// File: rtl/deallocator_pkg.sv
// Shared bridge definitions used by the packet read-out stage: page/line
// address widths, packet-word control code and packet-buffer request layout.
package deallocator_pkg;

    localparam int LL_PG_ASZ   = 6;
    localparam int PB_ASZ      = LL_PG_ASZ + 2;
    localparam int PFW_SZ      = 34;
    localparam int PRW_PCC_LO  = 32;
    localparam int PRW_PCC_HI  = 33;
    localparam int PBR_PORT_SZ = 4;

    typedef enum logic [1:0] {
        PCC_DATA    = 2'd0,
        PCC_SOP     = 2'd1,
        PCC_EOP     = 2'd2,
        PCC_SOP_EOP = 2'd3
    } pcc_e;

    typedef struct packed {
        logic [PB_ASZ-1:0]      addr;
        logic                   write;
        logic [PBR_PORT_SZ-1:0] port;
        logic [PFW_SZ-1:0]      data;
    } pbr_t;

    localparam int PBR_SZ = $bits(pbr_t);

    typedef enum logic [2:0] {
        s_idle,
        s_read,
        s_link_req,
        s_link_rsp,
        s_free,
        s_free_last
    } state_e;

    // Both end-of-packet codes carry bit 1 of the control field.
    function automatic logic any_eop(input logic [1:0] pcc);
        return pcc[1];
    endfunction

endpackage

// File: rtl/sd_iohalf.sv
// Single-entry registered srdy/drdy buffer; refills in the same cycle it
// drains, so an unstalled producer keeps one transfer per cycle.
module sd_iohalf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [WIDTH-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [WIDTH-1:0] p_data
);

    logic             full_p0;
    logic [WIDTH-1:0] data_p0;

    assign c_drdy = !full_p0 || p_drdy;

    // p0: output holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            full_p0 <= 1'b0;
        end else if (c_srdy && c_drdy) begin
            full_p0 <= 1'b1;
        end else if (p_drdy) begin
            full_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (c_srdy && c_drdy) begin
            data_p0 <= c_data;
        end
    end

    assign p_srdy = full_p0;
    assign p_data = data_p0;

endmodule

// File: rtl/deallocator.sv
// Packet read-out: walks a descriptor's page list, reads every line of every
// page, forwards returns up to EOP and frees each page once its reads drain.
module deallocator
    import deallocator_pkg::*;
#(
    parameter logic [PBR_PORT_SZ-1:0] port_num = PBR_PORT_SZ'(1)
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 f2d_srdy,
    output logic                 f2d_drdy,
    input  logic [LL_PG_ASZ-1:0] f2d_start,
    input  logic [LL_PG_ASZ-1:0] f2d_end,

    output logic                 rlp_srdy,
    input  logic                 rlp_drdy,
    output logic [LL_PG_ASZ-1:0] rlp_page,

    input  logic                 rlpr_srdy,
    output logic                 rlpr_drdy,
    input  logic [LL_PG_ASZ-1:0] rlpr_page,

    output logic                 drf_srdy,
    input  logic                 drf_drdy,
    output logic [LL_PG_ASZ-1:0] drf_page,

    output logic                 pbrd_srdy,
    input  logic                 pbrd_drdy,
    output logic [PBR_SZ-1:0]    pbrd_data,

    input  logic                 pbrr_srdy,
    output logic                 pbrr_drdy,
    input  logic [PFW_SZ-1:0]    pbrr_data,

    output logic                 ptx_srdy,
    input  logic                 ptx_drdy,
    output logic [PFW_SZ-1:0]    ptx_data
);

    state_e               state;
    logic [LL_PG_ASZ-1:0] end_pg;
    logic [LL_PG_ASZ-1:0] cur_pg;
    logic [LL_PG_ASZ-1:0] nxt_pg;
    logic [1:0]           cur_line;
    logic [2:0]           rd_cnt;
    logic                 drop;

    pbr_t req;
    logic req_srdy;
    logic req_drdy;
    logic req_fire;
    logic ret_fire;
    logic ret_dec;
    logic ret_eop;

    // Line 0 of the first page is issued together with the descriptor accept
    // so the first request is already at pbrd on the next cycle.
    always_comb begin
        req       = '0;
        req.port  = port_num;
        req.addr  = {cur_pg, cur_line};
        req_srdy  = 1'b0;
        case (state)
            s_idle: begin
                req_srdy = f2d_srdy;
                req.addr = {f2d_start, 2'b00};
            end
            s_read:  req_srdy = (rd_cnt < 3'd4);
            default: req_srdy = 1'b0;
        endcase
    end

    assign f2d_drdy = (state == s_idle) && req_drdy;
    assign req_fire = req_srdy && req_drdy;

    assign ptx_data  = pbrr_data;
    assign ptx_srdy  = pbrr_srdy && !drop;
    assign pbrr_drdy = drop || ptx_drdy;
    assign ret_fire  = pbrr_srdy && pbrr_drdy;
    // Stale returns after a mid-packet reset must not wrap the counter.
    assign ret_dec   = ret_fire && (rd_cnt != 3'd0);
    assign ret_eop   = any_eop(pbrr_data[PRW_PCC_HI:PRW_PCC_LO]);

    assign rlp_srdy  = (state == s_link_req);
    assign rlp_page  = cur_pg;
    assign rlpr_drdy = (state == s_link_rsp);
    assign drf_srdy  = ((state == s_free) || (state == s_free_last)) && (rd_cnt == 3'd0);
    assign drf_page  = cur_pg;

    sd_iohalf #(
        .WIDTH(PBR_SZ)
    ) obuf (
        .clk    (clk),
        .reset  (reset),
        .c_srdy (req_srdy),
        .c_drdy (req_drdy),
        .c_data (req),
        .p_srdy (pbrd_srdy),
        .p_drdy (pbrd_drdy),
        .p_data (pbrd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= s_idle;
            end_pg   <= '0;
            cur_pg   <= '0;
            nxt_pg   <= '0;
            cur_line <= '0;
            rd_cnt   <= '0;
            drop     <= 1'b0;
        end else begin
            if (req_fire && !ret_dec) begin
                rd_cnt <= rd_cnt + 3'd1;
            end else if (!req_fire && ret_dec) begin
                rd_cnt <= rd_cnt - 3'd1;
            end

            if (ret_fire && !drop && ret_eop) begin
                drop <= 1'b1;
            end

            case (state)
                s_idle: begin
                    if (f2d_srdy && f2d_drdy) begin
                        end_pg   <= f2d_end;
                        cur_pg   <= f2d_start;
                        cur_line <= 2'd1;
                        drop     <= 1'b0;
                        state    <= s_read;
                    end
                end
                s_read: begin
                    if (req_fire) begin
                        cur_line <= cur_line + 2'd1;
                        if (cur_line == 2'd3) begin
                            state <= (cur_pg == end_pg) ? s_free_last : s_link_req;
                        end
                    end
                end
                s_link_req: begin
                    if (rlp_drdy) begin
                        state <= s_link_rsp;
                    end
                end
                s_link_rsp: begin
                    if (rlpr_srdy) begin
                        nxt_pg <= rlpr_page;
                        state  <= s_free;
                    end
                end
                s_free: begin
                    if (drf_srdy && drf_drdy) begin
                        cur_pg   <= nxt_pg;
                        cur_line <= 2'd0;
                        state    <= s_read;
                    end
                end
                s_free_last: begin
                    if (drf_srdy && drf_drdy) begin
                        state <= s_idle;
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_deallocator.sv
// Directed bench for deallocator: drives descriptors, answers link and buffer
// reads from a small model and checks reads, frees and forwarded words.
module tb_deallocator;
    import deallocator_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 f2d_srdy, f2d_drdy;
    logic [LL_PG_ASZ-1:0] f2d_start, f2d_end;
    logic                 rlp_srdy, rlp_drdy;
    logic [LL_PG_ASZ-1:0] rlp_page;
    logic                 rlpr_srdy, rlpr_drdy;
    logic [LL_PG_ASZ-1:0] rlpr_page;
    logic                 drf_srdy, drf_drdy;
    logic [LL_PG_ASZ-1:0] drf_page;
    logic                 pbrd_srdy, pbrd_drdy;
    logic [PBR_SZ-1:0]    pbrd_data;
    logic                 pbrr_srdy, pbrr_drdy;
    logic [PFW_SZ-1:0]    pbrr_data;
    logic                 ptx_srdy, ptx_drdy;
    logic [PFW_SZ-1:0]    ptx_data;

    always #5 clk = ~clk;

    deallocator #(.port_num(PBR_PORT_SZ'(1))) dut (
        .clk(clk), .reset(reset),
        .f2d_srdy(f2d_srdy), .f2d_drdy(f2d_drdy), .f2d_start(f2d_start), .f2d_end(f2d_end),
        .rlp_srdy(rlp_srdy), .rlp_drdy(rlp_drdy), .rlp_page(rlp_page),
        .rlpr_srdy(rlpr_srdy), .rlpr_drdy(rlpr_drdy), .rlpr_page(rlpr_page),
        .drf_srdy(drf_srdy), .drf_drdy(drf_drdy), .drf_page(drf_page),
        .pbrd_srdy(pbrd_srdy), .pbrd_drdy(pbrd_drdy), .pbrd_data(pbrd_data),
        .pbrr_srdy(pbrr_srdy), .pbrr_drdy(pbrr_drdy), .pbrr_data(pbrr_data),
        .ptx_srdy(ptx_srdy), .ptx_drdy(ptx_drdy), .ptx_data(ptx_data)
    );

    pbr_t rq;
    assign rq = pbr_t'(pbrd_data);

    int vectors = 0;
    int miscompares = 0;

    logic [PB_ASZ-1:0]    rd_log[$];
    logic [PB_ASZ-1:0]    ret_q[$];
    logic [PFW_SZ-1:0]    ptx_log[$];
    logic [LL_PG_ASZ-1:0] drf_log[$];
    logic [LL_PG_ASZ-1:0] rlp_log[$];
    int                   drf_rdc[$];
    int                   drf_cyc[$];
    int                   rlpr_cyc[$];
    int                   cyc = 0;
    bit                   ptx_en = 1'b1;
    int                   link_delay = 1;
    int                   eop_addr = -1;
    logic [LL_PG_ASZ-1:0] next_pg[64];
    bit                   link_pend = 1'b0;
    int                   link_cnt = 0;
    logic [LL_PG_ASZ-1:0] link_val = '0;

    function automatic logic [PFW_SZ-1:0] word(input logic [PB_ASZ-1:0] a);
        logic [PFW_SZ-1:0] w;
        w = '0;
        w[PB_ASZ-1:0] = a;
        w[PRW_PCC_HI:PRW_PCC_LO] = (int'(a) == eop_addr) ? PCC_EOP : PCC_DATA;
        return w;
    endfunction

    // Environment: drives responses on the falling edge, then records every
    // handshake that will complete on the following rising edge.
    initial begin
        pbrd_drdy = 1'b1;
        rlp_drdy  = 1'b1;
        drf_drdy  = 1'b1;
        pbrr_srdy = 1'b0;
        pbrr_data = '0;
        rlpr_srdy = 1'b0;
        rlpr_page = '0;
        ptx_drdy  = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                ret_q.delete();
                link_pend = 1'b0;
            end
            pbrr_srdy = (ret_q.size() != 0);
            pbrr_data = (ret_q.size() != 0) ? word(ret_q[0]) : '0;
            ptx_drdy  = ptx_en;
            rlpr_srdy = link_pend && (link_cnt == 0);
            rlpr_page = link_val;
            #1;
            if (!reset) begin
                if (pbrr_srdy && pbrr_drdy) begin
                    void'(ret_q.pop_front());
                end
                if (ptx_srdy && ptx_drdy) ptx_log.push_back(ptx_data);
                if (pbrd_srdy && pbrd_drdy) begin
                    rd_log.push_back(rq.addr);
                    ret_q.push_back(rq.addr);
                end
                if (rlp_srdy && rlp_drdy) begin
                    rlp_log.push_back(rlp_page);
                    link_pend = 1'b1;
                    link_cnt  = link_delay;
                    link_val  = next_pg[rlp_page];
                end else if (link_pend) begin
                    if (rlpr_srdy && rlpr_drdy) begin
                        link_pend = 1'b0;
                        rlpr_cyc.push_back(cyc);
                    end else if (link_cnt > 0) begin
                        link_cnt--;
                    end
                end
                if (drf_srdy && drf_drdy) begin
                    drf_log.push_back(drf_page);
                    drf_rdc.push_back(int'(dut.rd_cnt));
                    drf_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        ptx_log.delete();
        drf_log.delete();
        rlp_log.delete();
        drf_rdc.delete();
        drf_cyc.delete();
        rlpr_cyc.delete();
    endtask

    task automatic send(input string tag, input int s, input int e);
        int   n;
        logic acc;
        n = 0;
        @(negedge clk);
        f2d_srdy  = 1'b1;
        f2d_start = LL_PG_ASZ'(s);
        f2d_end   = LL_PG_ASZ'(e);
        #1;
        while (!f2d_drdy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = f2d_drdy;
        @(negedge clk);
        f2d_srdy = 1'b0;
        #2;
        check({tag, "_accept"}, 64'(acc), 64'(1));
        check({tag, "_first_vld"}, 64'(pbrd_srdy), 64'(1));
        check({tag, "_first_addr"}, 64'(rq.addr), 64'(s * 4));
    endtask

    task automatic wait_free(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (drf_log.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        repeat (2) @(negedge clk);
        #2;
        check({tag, "_nfree"}, 64'(drf_log.size()), 64'(n));
        check({tag, "_idle"}, 64'(f2d_drdy), 64'(1));
        check({tag, "_rdcnt0"}, 64'(dut.rd_cnt), 64'(0));
    endtask

    task automatic check_walk(input string tag, input int p0, input int p1, input int p2,
                              input int npg, input int nptx);
        int pg[3];
        pg = '{p0, p1, p2};
        check({tag, "_nrd"}, 64'(rd_log.size()), 64'(4 * npg));
        check({tag, "_nptx"}, 64'(ptx_log.size()), 64'(nptx));
        for (int i = 0; i < 4 * npg && i < rd_log.size(); i++)
            check({tag, "_rd"}, 64'(rd_log[i]), 64'(pg[i / 4] * 4 + i % 4));
        for (int i = 0; i < npg && i < drf_log.size(); i++)
            check({tag, "_drf"}, 64'(drf_log[i]), 64'(pg[i]));
        for (int i = 0; i < nptx && i < ptx_log.size(); i++)
            check({tag, "_ptx"}, 64'(ptx_log[i]),
                  64'(word(PB_ASZ'(pg[i / 4] * 4 + i % 4))));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset     = 1'b1;
        f2d_srdy  = 1'b0;
        f2d_start = '0;
        f2d_end   = '0;
        for (int i = 0; i < 64; i++) next_pg[i] = '0;
        next_pg[2] = LL_PG_ASZ'(7);
        next_pg[7] = LL_PG_ASZ'(9);
        next_pg[3] = LL_PG_ASZ'(6);

        repeat (3) @(negedge clk);
        #2;
        check("rst_pbrd_srdy", 64'(pbrd_srdy), 64'(0));
        check("rst_rlp_srdy", 64'(rlp_srdy), 64'(0));
        check("rst_drf_srdy", 64'(drf_srdy), 64'(0));
        check("rst_ptx_srdy", 64'(ptx_srdy), 64'(0));
        check("rst_rd_cnt", 64'(dut.rd_cnt), 64'(0));
        check("rst_drop", 64'(dut.drop), 64'(0));
        check("rst_cur_pg", 64'(dut.cur_pg), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("idle_f2d_drdy", 64'(f2d_drdy), 64'(1));

        // Single page, EOP on second word
        clear_logs();
        eop_addr = 21;
        send("t1", 5, 5);
        check("t1_pbr_write", 64'(rq.write), 64'(0));
        check("t1_pbr_port", 64'(rq.port), 64'(1));
        check("t1_pbr_data", 64'(rq.data), 64'(0));
        wait_free("t1", 1, 200);
        check_walk("t1", 5, 0, 0, 1, 2);

        // Three pages, EOP on last page line 1
        clear_logs();
        eop_addr = 37;
        send("t2", 2, 9);
        wait_free("t2", 3, 300);
        check_walk("t2", 2, 7, 9, 3, 10);

        // Transmit stalled for 20 cycles while page 7 is being read
        clear_logs();
        eop_addr = 37;
        send("t3", 2, 9);
        k = 0;
        while (drf_log.size() < 1 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        ptx_en = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        check("t3_rd_cnt_sat", 64'(dut.rd_cnt), 64'(4));
        check("t3_pbrd_stall", 64'(pbrd_srdy), 64'(0));
        check("t3_no_free", 64'(drf_srdy), 64'(0));
        check("t3_ptx_held", 64'(ptx_srdy), 64'(1));
        check("t3_ptx_count", 64'(ptx_log.size()), 64'(4));
        ptx_en = 1'b1;
        wait_free("t3", 3, 300);
        check_walk("t3", 2, 7, 9, 3, 10);

        // Link response delayed by 10 cycles
        clear_logs();
        eop_addr   = 37;
        link_delay = 10;
        send("t4", 2, 9);
        wait_free("t4", 3, 400);
        check_walk("t4", 2, 7, 9, 3, 10);
        check("t4_nrlp", 64'(rlp_log.size()), 64'(2));
        if (rlp_log.size() > 0) check("t4_rlp0", 64'(rlp_log[0]), 64'(2));
        if (drf_rdc.size() > 0) check("t4_free_rdcnt", 64'(drf_rdc[0]), 64'(0));
        if (drf_cyc.size() > 0 && rlpr_cyc.size() > 0)
            check("t4_free_after_link", 64'(drf_cyc[0]), 64'(rlpr_cyc[0] + 1));
        link_delay = 1;

        // EOP on the very first word of a three-page packet
        clear_logs();
        eop_addr = 8;
        send("t5", 2, 9);
        wait_free("t5", 3, 300);
        check_walk("t5", 2, 7, 9, 3, 1);

        // Reset in the middle of a two-page packet, then a fresh packet
        clear_logs();
        eop_addr = -1;
        send("t6a", 3, 6);
        k = 0;
        while (rd_log.size() < 2 && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("t6_rst_pbrd_srdy", 64'(pbrd_srdy), 64'(0));
        check("t6_rst_rlp_srdy", 64'(rlp_srdy), 64'(0));
        check("t6_rst_drf_srdy", 64'(drf_srdy), 64'(0));
        check("t6_rst_ptx_srdy", 64'(ptx_srdy), 64'(0));
        check("t6_rst_rd_cnt", 64'(dut.rd_cnt), 64'(0));
        check("t6_rst_f2d_drdy", 64'(f2d_drdy), 64'(1));
        reset = 1'b0;
        clear_logs();
        eop_addr = 18;
        send("t6b", 4, 4);
        wait_free("t6b", 1, 200);
        check_walk("t6b", 4, 0, 0, 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
